// File: rtl/hyperbus_arbiter_if.sv
// Signal bundle between hyperbus_arbiter, its two requesters and the hyperbus controller.
// master is the arbiter's view; slave is the requester/controller side.
interface hyperbus_arbiter_if #(
  parameter int WIDTH     = 8,
  parameter int LEN_WIDTH = 8
);
  logic                   p0_req, p1_req;
  logic                   p0_we, p1_we;
  logic                   p0_reg_space, p1_reg_space;
  logic [31:0]            p0_adr, p1_adr;
  logic [LEN_WIDTH-1:0]   p0_len, p1_len;
  logic [2*WIDTH-1:0]     p0_wdat, p1_wdat;
  logic                   p0_gnt, p1_gnt;
  logic                   p0_wready, p1_wready;
  logic                   p0_rvalid, p1_rvalid;
  logic                   p0_done, p1_done;
  logic                   p0_err, p1_err;
  logic [2*WIDTH-1:0]     rdat;
  logic                   fault;
  logic [31:0]            ctl_adr;
  logic [2*WIDTH-1:0]     ctl_dat;
  logic                   ctl_reg_space, ctl_wrq, ctl_rrq;
  logic [2*WIDTH-1:0]     ctl_rdat;
  logic                   ctl_ready, ctl_valid, ctl_busy, ctl_error;

  modport master (
    input  p0_req, p0_we, p0_reg_space, p0_adr, p0_len, p0_wdat,
    input  p1_req, p1_we, p1_reg_space, p1_adr, p1_len, p1_wdat,
    input  ctl_rdat, ctl_ready, ctl_valid, ctl_busy, ctl_error,
    output p0_gnt, p0_wready, p0_rvalid, p0_done, p0_err,
    output p1_gnt, p1_wready, p1_rvalid, p1_done, p1_err,
    output rdat, fault, ctl_adr, ctl_dat, ctl_reg_space, ctl_wrq, ctl_rrq
  );

  modport slave (
    output p0_req, p0_we, p0_reg_space, p0_adr, p0_len, p0_wdat,
    output p1_req, p1_we, p1_reg_space, p1_adr, p1_len, p1_wdat,
    output ctl_rdat, ctl_ready, ctl_valid, ctl_busy, ctl_error,
    input  p0_gnt, p0_wready, p0_rvalid, p0_done, p0_err,
    input  p1_gnt, p1_wready, p1_rvalid, p1_done, p1_err,
    input  rdat, fault, ctl_adr, ctl_dat, ctl_reg_space, ctl_wrq, ctl_rrq
  );
endinterface

// File: rtl/hyperbus_arbiter.sv
// Two-port round-robin arbiter and burst sequencer in front of the hyperbus controller.
// Optional progress watchdog is built when HYPERBUS_ARB_TIMEOUT_EN is defined.
module hyperbus_arbiter #(
  parameter int WIDTH     = 8,
  parameter int LEN_WIDTH = 8,
  parameter int TIMEOUT   = 255
) (
  input  logic              clk,
  input  logic              rstn,
  hyperbus_arbiter_if.master bus
);
  localparam int W = 2 * WIDTH;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] XFER    = 2'd1;
  localparam logic [1:0] RELEASE = 2'd2;
  localparam logic [1:0] FAULT   = 2'd3;

  logic [1:0]           state;
  logic                 sel;
  logic                 last;
  logic                 we_q;
  logic                 tmo_hit;
  logic [LEN_WIDTH-1:0] cnt;
  logic [W-1:0]         dat_hold;

  logic                 req0, req1, any_req, win;
  logic                 g_we, g_rs;
  logic [31:0]          g_adr;
  logic [LEN_WIDTH-1:0] g_len;
  logic                 xfer_wr, xfer_rd, word, last_word, tmo;
  logic [W-1:0]         wdat_sel;

  // A port whose done is pulsing still shows the old request this cycle.
  assign req0    = bus.p0_req & ~bus.p0_done;
  assign req1    = bus.p1_req & ~bus.p1_done;
  assign any_req = req0 | req1;
  assign win     = (req0 & req1) ? ~last : req1;

  assign g_we  = win ? bus.p1_we        : bus.p0_we;
  assign g_rs  = win ? bus.p1_reg_space : bus.p0_reg_space;
  assign g_adr = win ? bus.p1_adr       : bus.p0_adr;
  assign g_len = win ? bus.p1_len       : bus.p0_len;

  assign xfer_wr   = (state == XFER) & we_q;
  assign xfer_rd   = (state == XFER) & ~we_q;
  assign word      = xfer_wr ? bus.ctl_ready : (xfer_rd & bus.ctl_valid);
  assign last_word = word & (cnt == '0);

  assign wdat_sel      = sel ? bus.p1_wdat : bus.p0_wdat;
  assign bus.ctl_dat   = xfer_wr ? wdat_sel : dat_hold;
  assign bus.p0_wready = xfer_wr & bus.ctl_ready & ~sel;
  assign bus.p1_wready = xfer_wr & bus.ctl_ready &  sel;
  assign bus.p0_rvalid = xfer_rd & bus.ctl_valid & ~sel;
  assign bus.p1_rvalid = xfer_rd & bus.ctl_valid &  sel;
  assign bus.rdat      = xfer_rd ? bus.ctl_rdat : '0;

`ifdef HYPERBUS_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_cnt;

  // Counts XFER cycles since the grant or the most recent word.
  assign tmo = (state == XFER) & ~word & (tmo_cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      tmo_cnt <= '0;
    else if (state != XFER || word)
      tmo_cnt <= '0;
    else
      tmo_cnt <= tmo_cnt + TW'(1);
  end
`else
  // No watchdog in this build; TIMEOUT has no effect.
  assign tmo = 1'b0 & (TIMEOUT > 0);
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state             <= IDLE;
      sel               <= 1'b0;
      last              <= 1'b1;
      we_q              <= 1'b0;
      tmo_hit           <= 1'b0;
      cnt               <= '0;
      dat_hold          <= '0;
      bus.ctl_adr       <= '0;
      bus.ctl_reg_space <= 1'b0;
      bus.ctl_wrq       <= 1'b0;
      bus.ctl_rrq       <= 1'b0;
      bus.fault         <= 1'b0;
      bus.p0_gnt        <= 1'b0;
      bus.p1_gnt        <= 1'b0;
      bus.p0_done       <= 1'b0;
      bus.p1_done       <= 1'b0;
      bus.p0_err        <= 1'b0;
      bus.p1_err        <= 1'b0;
    end else begin
      bus.p0_gnt  <= 1'b0;
      bus.p1_gnt  <= 1'b0;
      bus.p0_done <= 1'b0;
      bus.p1_done <= 1'b0;
      bus.p0_err  <= 1'b0;
      bus.p1_err  <= 1'b0;
      if (xfer_wr)
        dat_hold <= wdat_sel;

      if (bus.ctl_error) begin
        state       <= FAULT;
        bus.fault   <= 1'b1;
        bus.ctl_wrq <= 1'b0;
        bus.ctl_rrq <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (!bus.ctl_busy && any_req) begin
              state             <= XFER;
              sel               <= win;
              we_q              <= g_we;
              cnt               <= g_len;
              tmo_hit           <= 1'b0;
              bus.ctl_adr       <= g_adr;
              bus.ctl_reg_space <= g_rs;
              bus.ctl_wrq       <= g_we;
              bus.ctl_rrq       <= ~g_we;
              bus.p0_gnt        <= ~win;
              bus.p1_gnt        <= win;
            end
          end
          XFER: begin
            if (word)
              cnt <= cnt - LEN_WIDTH'(1);
            if (last_word || tmo) begin
              state       <= RELEASE;
              tmo_hit     <= tmo;
              bus.ctl_wrq <= 1'b0;
              bus.ctl_rrq <= 1'b0;
            end
          end
          RELEASE: begin
            if (!bus.ctl_busy) begin
              state       <= IDLE;
              last        <= sel;
              bus.p0_done <= ~sel;
              bus.p1_done <= sel;
              bus.p0_err  <= ~sel & tmo_hit;
              bus.p1_err  <= sel & tmo_hit;
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_hyperbus_arbiter.sv
// Self-checking bench for hyperbus_arbiter: vector table, hand-written corner sequences and
// randomized two-port traffic against a transaction-level reference model.
`timescale 1ns/1ps
module tb_hyperbus_arbiter;
  localparam int WIDTH     = 8;
  localparam int LEN_WIDTH = 8;
  localparam int TIMEOUT   = 16;
  localparam int W         = 2 * WIDTH;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  hyperbus_arbiter_if #(.WIDTH(WIDTH), .LEN_WIDTH(LEN_WIDTH)) bus ();
  hyperbus_arbiter #(.WIDTH(WIDTH), .LEN_WIDTH(LEN_WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rstn(rstn), .bus(bus)
  );

  typedef struct {
    bit                   we;
    bit                   rs;
    logic [31:0]          adr;
    logic [LEN_WIDTH-1:0] len;
    logic [W-1:0]         seed;
    int                   at;
  } job_t;
  typedef struct { bit port; int words; bit err; } res_t;
  typedef struct {
    bit port; bit we; bit rs; logic [31:0] adr; logic [LEN_WIDTH-1:0] len; int exp_words;
  } vec_t;

  int   tests = 0, fails = 0;
  int   model_last = 1;
  job_t jq0[$], jq1[$];
  res_t results[$];
  int   gnt_order[$];

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] wval(job_t j, int idx);
    return j.seed + W'(idx * 257);
  endfunction

  function automatic int qsize(int p);
    return (p == 1) ? jq1.size() : (p == 0) ? jq0.size() : 0;
  endfunction

  task automatic clear_inputs();
    bus.p0_req = 0; bus.p0_we = 0; bus.p0_reg_space = 0; bus.p0_adr = '0; bus.p0_len = '0; bus.p0_wdat = '0;
    bus.p1_req = 0; bus.p1_we = 0; bus.p1_reg_space = 0; bus.p1_adr = '0; bus.p1_len = '0; bus.p1_wdat = '0;
    bus.ctl_rdat = '0; bus.ctl_ready = 0; bus.ctl_valid = 0; bus.ctl_busy = 0; bus.ctl_error = 0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    clear_inputs();
    model_last = 1;
    jq0.delete(); jq1.delete(); results.delete(); gnt_order.delete();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic check_idle_outputs(string name);
    check({name, "_ctrl"}, 64'({bus.p0_gnt, bus.p1_gnt, bus.p0_wready, bus.p1_wready, bus.p0_rvalid,
                                bus.p1_rvalid, bus.p0_done, bus.p1_done, bus.p0_err, bus.p1_err,
                                bus.fault, bus.ctl_wrq, bus.ctl_rrq, bus.ctl_reg_space}), 64'(0));
    check({name, "_adr"}, 64'(bus.ctl_adr), 64'(0));
    check({name, "_data"}, 64'({bus.ctl_dat, bus.rdat}), 64'(0));
  endtask

  // Requesters serve their job queues; the controller model strobes ready/valid at random
  // (never more than two idle cycles in a row) and stays busy a few cycles after a burst.
  task automatic run_env(int max_cycles);
    int owner = -1, widx = 0, tail = 0, gap = 0, cyc = 0, p, expw;
    bit act = 0, prev_act = 0, epr0 = 0, epr1 = 0, fire, any;
    job_t cur;
    logic [W-1:0] rd;
    while (1) begin
      @(negedge clk);
      check("dual_gnt", 64'(bus.p0_gnt & bus.p1_gnt), 64'(0));
      if (bus.p0_gnt || bus.p1_gnt) begin
        p    = bus.p1_gnt ? 1 : 0;
        expw = (epr0 && epr1) ? 1 - model_last : (epr1 ? 1 : 0);
        check("gnt_port", 64'(p), 64'(expw));
        check("gnt_pending", 64'(qsize(p) > 0), 64'(1));
        owner = p; widx = 0;
        gnt_order.push_back(p);
        if (qsize(p) > 0) begin
          cur = (p == 1) ? jq1[0] : jq0[0];
          check("gnt_adr", 64'(bus.ctl_adr), 64'(cur.adr));
          check("gnt_rs", 64'(bus.ctl_reg_space), 64'(cur.rs));
          check("gnt_dir", 64'({bus.ctl_wrq, bus.ctl_rrq}), 64'({cur.we, ~cur.we}));
        end
      end
      if (bus.p0_done || bus.p1_done) begin
        p = bus.p1_done ? 1 : 0;
        check("done_owner", 64'(p), 64'(owner));
        results.push_back('{p[0], widx, (p == 1) ? bus.p1_err : bus.p0_err});
        if (p == 0 && jq0.size() > 0) jq0.delete(0);
        if (p == 1 && jq1.size() > 0) jq1.delete(0);
        model_last = p;
        owner = -1;
      end
      if (jq0.size() == 0 && jq1.size() == 0 && owner == -1) break;
      cyc++;
      if (cyc > max_cycles) begin
        check("env_budget", 64'(cyc), 64'(max_cycles));
        break;
      end

      bus.p0_req = jq0.size() > 0 && cyc >= jq0[0].at;
      bus.p1_req = jq1.size() > 0 && cyc >= jq1[0].at;
      if (jq0.size() > 0) begin
        bus.p0_we = jq0[0].we; bus.p0_reg_space = jq0[0].rs; bus.p0_adr = jq0[0].adr;
        bus.p0_len = jq0[0].len; bus.p0_wdat = wval(jq0[0], (owner == 0) ? widx : 0);
      end
      if (jq1.size() > 0) begin
        bus.p1_we = jq1[0].we; bus.p1_reg_space = jq1[0].rs; bus.p1_adr = jq1[0].adr;
        bus.p1_len = jq1[0].len; bus.p1_wdat = wval(jq1[0], (owner == 1) ? widx : 0);
      end
      epr0 = bus.p0_req && !bus.p0_done;
      epr1 = bus.p1_req && !bus.p1_done;

      act = bus.ctl_wrq | bus.ctl_rrq;
      if (prev_act && !act) tail = $urandom_range(0, 2);
      prev_act = act;
      if (act) bus.ctl_busy = 1;
      else if (tail > 0) begin bus.ctl_busy = 1; tail--; end
      else bus.ctl_busy = 0;
      fire = (gap >= 2) || ($urandom_range(0, 2) != 0);
      gap  = (act && !fire) ? gap + 1 : 0;
      rd   = W'($urandom);
      bus.ctl_rdat  = rd;
      // Strobes during RELEASE are noise that must not reach the ports.
      bus.ctl_ready = act ? (bus.ctl_wrq & fire) : (owner >= 0 && $urandom_range(0, 1) == 1);
      bus.ctl_valid = act ? (bus.ctl_rrq & fire) : (owner >= 0 && $urandom_range(0, 1) == 1);

      #1;
      any = bus.p0_wready | bus.p1_wready;
      check("wready_follows", 64'(any), 64'(bus.ctl_wrq & bus.ctl_ready));
      if (any) begin
        check("wready_port", 64'(bus.p1_wready), 64'(owner == 1));
        if (qsize(owner) > 0)
          check("ctl_dat", 64'(bus.ctl_dat), 64'(wval((owner == 1) ? jq1[0] : jq0[0], widx)));
        widx++;
      end
      any = bus.p0_rvalid | bus.p1_rvalid;
      check("rvalid_follows", 64'(any), 64'(bus.ctl_rrq & bus.ctl_valid));
      if (any) begin
        check("rvalid_port", 64'(bus.p1_rvalid), 64'(owner == 1));
        check("rdat", 64'(bus.rdat), 64'(rd));
        widx++;
      end
    end
    clear_inputs();
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t vecs[6];
    int   n, fall, nd;
    job_t j;
    int   e0[$], e1[$];

    vecs[0] = '{0, 1, 0, 32'h0000_0100, 8'd3,   4};
    vecs[1] = '{1, 0, 1, 32'h0000_2000, 8'd0,   1};
    vecs[2] = '{0, 0, 0, 32'hFFFF_FFFC, 8'd15, 16};
    vecs[3] = '{1, 1, 1, 32'h0000_0000, 8'd255, 256};
    vecs[4] = '{0, 1, 1, 32'hDEAD_BEEF, 8'd1,   2};
    vecs[5] = '{1, 0, 0, 32'h1234_5678, 8'd7,   8};

    // Reset state
    do_reset();
    check_idle_outputs("reset");

    // Port 0 write of 4 words with ready held for 6 cycles
    bus.p0_req = 1; bus.p0_we = 1; bus.p0_adr = 32'h100; bus.p0_len = 8'd3; bus.p0_wdat = 16'hA000;
    @(negedge clk);
    check("w4_gnt", 64'({bus.p0_gnt, bus.p1_gnt, bus.ctl_wrq, bus.ctl_rrq}), 64'(4'b1010));
    check("w4_adr", 64'(bus.ctl_adr), 64'(32'h100));
    bus.ctl_busy = 1;
    n = 0; fall = -1;
    for (int i = 0; i < 6; i++) begin
      bus.ctl_ready = 1; bus.p0_wdat = 16'hA000 + 16'(i);
      #1;
      if (bus.p0_wready) begin
        check("w4_dat", 64'(bus.ctl_dat), 64'(16'hA000 + 16'(i)));
        n++;
      end
      @(negedge clk);
      if (!bus.ctl_wrq && fall < 0) fall = i;
    end
    check("w4_wready_count", 64'(n), 64'(4));
    check("w4_wrq_fall", 64'(fall), 64'(3));
    bus.ctl_ready = 0; bus.ctl_busy = 0;
    nd = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.p0_done) begin
        nd++; bus.p0_req = 0;
        check("w4_err", 64'(bus.p0_err), 64'(0));
      end
    end
    check("w4_done_count", 64'(nd), 64'(1));

    // Port 1 single-word register-space read
    bus.p1_req = 1; bus.p1_we = 0; bus.p1_reg_space = 1; bus.p1_adr = 32'h55; bus.p1_len = 8'd0;
    @(negedge clk);
    check("r1_gnt", 64'({bus.p0_gnt, bus.p1_gnt, bus.ctl_wrq, bus.ctl_rrq, bus.ctl_reg_space}), 64'(5'b01011));
    bus.ctl_busy = 1; bus.ctl_valid = 1; bus.ctl_rdat = 16'hBEEF;
    #1;
    check("r1_rvalid", 64'({bus.p0_rvalid, bus.p1_rvalid}), 64'(2'b01));
    check("r1_rdat", 64'(bus.rdat), 64'(16'hBEEF));
    @(negedge clk);
    bus.ctl_valid = 0;
    check("r1_rrq_low", 64'(bus.ctl_rrq), 64'(0));
    check("r1_no_early_done", 64'(bus.p1_done), 64'(0));
    bus.ctl_busy = 0;
    @(negedge clk);
    check("r1_done", 64'({bus.p1_done, bus.p1_err, bus.p0_done}), 64'(3'b100));
    bus.p1_req = 0;
    @(negedge clk);
    check("r1_done_pulse", 64'(bus.p1_done), 64'(0));

    // Both ports request from reset, 2-word bursts: grants alternate
    do_reset();
    for (int i = 0; i < 2; i++) begin
      jq0.push_back('{1'($urandom), 1'b0, 32'h40 + 32'(i), 8'd1, W'($urandom), 0});
      jq1.push_back('{1'($urandom), 1'b1, 32'h80 + 32'(i), 8'd1, W'($urandom), 0});
    end
    run_env(400);
    check("rr_count", 64'(gnt_order.size()), 64'(4));
    for (int i = 0; i < 4 && i < gnt_order.size(); i++)
      check($sformatf("rr_order_%0d", i), 64'(gnt_order[i]), 64'(i % 2));

    // Table of single transactions
    for (int v = 0; v < 6; v++) begin
      results.delete();
      j = '{vecs[v].we, vecs[v].rs, vecs[v].adr, vecs[v].len, W'($urandom), 0};
      if (vecs[v].port) jq1.push_back(j); else jq0.push_back(j);
      run_env(2000);
      check($sformatf("vec%0d_count", v), 64'(results.size()), 64'(1));
      if (results.size() > 0) begin
        check($sformatf("vec%0d_port", v), 64'(results[0].port), 64'(vecs[v].port));
        check($sformatf("vec%0d_words", v), 64'(results[0].words), 64'(vecs[v].exp_words));
        check($sformatf("vec%0d_err", v), 64'(results[0].err), 64'(0));
      end
    end

    // Randomized traffic on both ports
    do_reset();
    for (int i = 0; i < 24; i++) begin
      j = '{1'($urandom), 1'($urandom), $urandom, 8'($urandom_range(0, 15)), W'($urandom),
            $urandom_range(0, 400)};
      if ($urandom_range(0, 1) == 1) begin jq1.push_back(j); e1.push_back(int'(j.len) + 1); end
      else begin jq0.push_back(j); e0.push_back(int'(j.len) + 1); end
    end
    run_env(6000);
    check("rand_count", 64'(results.size()), 64'(24));
    foreach (results[i]) begin
      n = -1;
      if (results[i].port && e1.size() > 0) n = e1.pop_front();
      if (!results[i].port && e0.size() > 0) n = e0.pop_front();
      check($sformatf("rand%0d_words", i), 64'(results[i].words), 64'(n));
      check($sformatf("rand%0d_err", i), 64'(results[i].err), 64'(0));
    end

    // Controller error in the middle of a write burst
    do_reset();
    bus.p0_req = 1; bus.p0_we = 1; bus.p0_adr = 32'h300; bus.p0_len = 8'd7;
    @(negedge clk);
    bus.ctl_busy = 1; bus.ctl_ready = 1;
    repeat (2) @(negedge clk);
    bus.ctl_ready = 0; bus.ctl_error = 1;
    @(negedge clk);
    bus.ctl_error = 0; bus.ctl_busy = 0;
    check("err_fault", 64'({bus.fault, bus.ctl_wrq, bus.ctl_rrq}), 64'(3'b100));
    nd = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.p0_done || bus.p1_done || bus.p0_gnt || bus.p1_gnt || bus.ctl_wrq || !bus.fault) nd++;
    end
    check("err_stuck", 64'(nd), 64'(0));
    bus.p0_req = 0;
    rstn = 0;
    #1;
    check_idle_outputs("err_reset");
    @(negedge clk);
    rstn = 1;
    @(negedge clk);
    check_idle_outputs("err_after");
    bus.p1_req = 1; bus.p1_we = 0; bus.p1_len = 8'd0;
    @(negedge clk);
    check("err_regrant", 64'({bus.p1_gnt, bus.ctl_rrq}), 64'(2'b11));

    // Stalled read: watchdog or indefinite wait
    do_reset();
    bus.p0_req = 1; bus.p0_we = 0; bus.p0_adr = 32'h500; bus.p0_len = 8'd7;
    @(negedge clk);
    bus.ctl_busy = 1; bus.ctl_valid = 1;
    repeat (2) @(negedge clk);
    bus.ctl_valid = 0;
`ifdef HYPERBUS_ARB_TIMEOUT_EN
    n = 0;
    for (int i = 0; i < 40 && bus.ctl_rrq; i++) begin
      @(negedge clk);
      n++;
    end
    check("tmo_cycles", 64'(n), 64'(TIMEOUT));
    bus.ctl_busy = 0;
    @(negedge clk);
    check("tmo_done_err", 64'({bus.p0_done, bus.p0_err}), 64'(2'b11));
`else
    repeat (1000) @(negedge clk);
    check("stall_rrq_held", 64'({bus.ctl_rrq, bus.p0_done}), 64'(2'b10));
`endif

    // Asynchronous reset in the middle of a burst
    do_reset();
    bus.p1_req = 1; bus.p1_we = 1; bus.p1_adr = 32'h700; bus.p1_len = 8'd5;
    @(negedge clk);
    bus.ctl_busy = 1; bus.ctl_ready = 1;
    @(negedge clk);
    #2;
    rstn = 0;
    #1;
    check_idle_outputs("async_rst");
    bus.ctl_ready = 0; bus.ctl_busy = 0; bus.p1_req = 0;
    @(negedge clk);
    rstn = 1;
    bus.p0_req = 1; bus.p0_we = 0; bus.p0_len = 8'd0;
    bus.p1_req = 1; bus.p1_we = 1; bus.p1_len = 8'd0;
    @(negedge clk);
    check("async_first_winner", 64'({bus.p0_gnt, bus.p1_gnt}), 64'(2'b10));
    do_reset();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
